basics_master: RTL

BASICS_MASTER -- requirements
Module: basics_master

---
 rtl/basics_pkg.sv | 39 +++
 rtl/basics_frame_tx.sv | 75 +++++++
 rtl/basics_master.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/basics_pkg.sv
// basics_pkg
// Shared definitions for the basics request/response protocol, used by
// both the master and the responder side: request opcodes, parameter
// selectors, response codes, the command type encoding and the master
// state encoding.
package basics_pkg;

  // Request address bytes (opcodes)
  localparam logic [7:0] OP_VER   = 8'h76;
  localparam logic [7:0] OP_QUERY = 8'h49;
  localparam logic [7:0] OP_SET   = 8'h69;

  // I2C parameter selectors
  localparam logic [7:0] SEL_SPEED = 8'h63;
  localparam logic [7:0] SEL_ADDR  = 8'h61;

  // Response codes; anything other than ACK is treated as a NAK
  localparam logic [7:0] CODE_ACK = 8'h00;
  localparam logic [7:0] CODE_NAK = 8'h01;

  // Longest request frame is SET_I2C address: 6 bytes
  localparam int MAX_FRAME_BYTES = 6;

  typedef enum logic [1:0] {
    CMD_VER   = 2'd0,
    CMD_QUERY = 2'd1,
    CMD_SET   = 2'd2,
    CMD_RSVD  = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DATA = 3'd3,
    ST_FINISH    = 3'd4
  } state_e;

endpackage

// File: rtl/basics_frame_tx.sv
// basics_frame_tx
// Serializes a request frame of up to MAX_FRAME_BYTES bytes onto a
// valid/ready byte stream with a frame envelope.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   start_i       load bytes_i/len_i and begin sending (ignored while busy)
//   bytes_i       byte list, element 0 is sent first
//   len_i         number of bytes to send (1..MAX_FRAME_BYTES)
//   data_o        current byte, held until accepted
//   valid_o       data_o valid this cycle
//   frame_o       frame envelope, high from first byte through last transfer
//   ready_i       sink accepts data_o this cycle
//   last_o        the final byte transfers this cycle
module basics_frame_tx
  import basics_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_i,
  input  logic [MAX_FRAME_BYTES-1:0][7:0] bytes_i,
  input  logic [2:0]                      len_i,
  output logic [7:0]                      data_o,
  output logic                            valid_o,
  output logic                            frame_o,
  input  logic                            ready_i,
  output logic                            last_o
);

  logic [MAX_FRAME_BYTES-1:0][7:0] buf_q, buf_d;
  logic [2:0]                      len_q, len_d;
  logic [2:0]                      idx_q, idx_d;
  logic                            busy_q, busy_d;

  // Envelope and valid are both just "busy", so the envelope drops the
  // cycle after the last handshake clears busy.
  assign valid_o = busy_q;
  assign frame_o = busy_q;
  assign data_o  = busy_q ? buf_q[idx_q] : 8'h00;
  assign last_o  = busy_q && ready_i && (idx_q == len_q - 3'd1);

  // Next-state: load on start, advance the byte index on each handshake,
  // and release the frame after the final byte.
  always_comb begin
    buf_d  = buf_q;
    len_d  = len_q;
    idx_d  = idx_q;
    busy_d = busy_q;
    if (start_i && !busy_q) begin
      buf_d  = bytes_i;
      len_d  = len_i;
      idx_d  = 3'd0;
      busy_d = 1'b1;
    end else if (last_o) begin
      idx_d  = 3'd0;
      busy_d = 1'b0;
    end else if (valid_o && ready_i) begin
      idx_d = idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q  <= '0;
      len_q  <= 3'd0;
      idx_q  <= 3'd0;
      busy_q <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      len_q  <= len_d;
      idx_q  <= idx_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/basics_master.sv
// basics_master
// Issues VER / QUERY_I2C / SET_I2C request frames, then parses the
// ACK/NAK response frame and an optional follow-up data frame.
// Ports:
//   clk, rst                  clock and asynchronous active-high reset
//   cmd_start/type/sel/wdata  command request (ignored while cmd_busy)
//   cmd_busy                  command in progress
//   ma_data/_valid/_frame_valid, ma_ready   request byte stream
//   rs_data/_valid/_frame_valid             response byte stream
//   done                      one-cycle completion pulse
//   ack, nak, timeout         status of the last command
//   rdata                     returned version or parameter value
//   eid                       exchange id of the current/last request
module basics_master
  import basics_pkg::*;
#(
  parameter logic [7:0]  VERSION_MAJOR  = 8'h00,
  parameter logic [7:0]  VERSION_MINOR  = 8'h01,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_start,
  input  logic [1:0]  cmd_type,
  input  logic        cmd_sel,
  input  logic [15:0] cmd_wdata,
  output logic        cmd_busy,
  output logic [7:0]  ma_data,
  output logic        ma_data_valid,
  output logic        ma_frame_valid,
  input  logic        ma_ready,
  input  logic [7:0]  rs_data,
  input  logic        rs_data_valid,
  input  logic        rs_frame_valid,
  output logic        done,
  output logic        ack,
  output logic        nak,
  output logic        timeout,
  output logic [15:0] rdata,
  output logic [7:0]  eid
);

  state_e      state_q, state_d;
  cmd_e        type_q, type_d;
  logic        sel_q, sel_d;
  logic [7:0]  eid_q, eid_d;
  logic        ack_q, ack_d, nak_q, nak_d, to_q, to_d;
  logic [15:0] rdata_q, rdata_d;
  logic [7:0]  code_q, code_d;
  logic        match_q, match_d;
  logic [1:0]  exp_q, exp_d;
  logic [15:0] cnt_q, cnt_d;
  logic        rsPrev_q, rsOpen_q;
  logic [2:0]  rsCnt_q;

  logic                            txStart, txLast;
  logic [MAX_FRAME_BYTES-1:0][7:0] txBytes;
  logic [2:0]                      txLen;
  logic [7:0]                      nextEid;
  logic                            listening, rsOpenNow, rsByte, rsEnd, timeoutHit;

  assign nextEid = eid_q + 8'd1;

  // A response frame only counts if its envelope rose while we were
  // listening; a frame already in flight on entry is skipped entirely.
  assign listening  = (state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_DATA);
  assign rsOpenNow  = listening && rs_frame_valid && (rsOpen_q || !rsPrev_q);
  assign rsByte     = rsOpenNow && rs_data_valid;
  assign rsEnd      = listening && rsOpen_q && !rs_frame_valid;
  assign timeoutHit = (cnt_q == TIMEOUT_CYCLES - 16'd1);

  // Build the request frame straight from the command inputs so the
  // serializer can load it on the same edge the command is accepted.
  always_comb begin
    txBytes = '0;
    txLen   = 3'd0;
    txBytes[1] = nextEid;
    case (cmd_type)
      CMD_VER: begin
        txBytes[0] = OP_VER;
        txBytes[2] = 8'h02;
        txBytes[3] = VERSION_MAJOR;
        txBytes[4] = VERSION_MINOR;
        txLen      = 3'd5;
      end
      CMD_QUERY: begin
        txBytes[0] = OP_QUERY;
        txBytes[2] = 8'h01;
        txBytes[3] = cmd_sel ? SEL_ADDR : SEL_SPEED;
        txLen      = 3'd4;
      end
      CMD_SET: begin
        txBytes[0] = OP_SET;
        if (cmd_sel) begin
          txBytes[2] = 8'h03;
          txBytes[3] = SEL_ADDR;
          txBytes[4] = cmd_wdata[15:8];
          txBytes[5] = cmd_wdata[7:0];
          txLen      = 3'd6;
        end else begin
          txBytes[2] = 8'h02;
          txBytes[3] = SEL_SPEED;
          txBytes[4] = cmd_wdata[7:0];
          txLen      = 3'd5;
        end
      end
      default: ;
    endcase
  end

  basics_frame_tx u_tx (
    .clk     (clk),
    .rst     (rst),
    .start_i (txStart),
    .bytes_i (txBytes),
    .len_i   (txLen),
    .data_o  (ma_data),
    .valid_o (ma_data_valid),
    .frame_o (ma_frame_valid),
    .ready_i (ma_ready),
    .last_o  (txLast)
  );

  // Command FSM: accept, send, collect the ACK/NAK frame, optionally a
  // data frame, then pulse done from FINISH.
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    sel_d   = sel_q;
    eid_d   = eid_q;
    ack_d   = ack_q;
    nak_d   = nak_q;
    to_d    = to_q;
    rdata_d = rdata_q;
    code_d  = code_q;
    match_d = match_q;
    exp_d   = exp_q;
    txStart = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          type_d  = cmd_e'(cmd_type);
          sel_d   = cmd_sel;
          eid_d   = nextEid;
          ack_d   = 1'b0;
          nak_d   = 1'b0;
          to_d    = 1'b0;
          rdata_d = 16'h0000;
          if (cmd_e'(cmd_type) == CMD_RSVD) begin
            nak_d   = 1'b1;
            state_d = ST_FINISH;
          end else begin
            txStart = 1'b1;
            state_d = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (txLast) state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (rsByte) begin
          if (rsCnt_q == 3'd0)      code_d  = rs_data;
          else if (rsCnt_q == 3'd1) match_d = (rs_data == eid_q);
        end
        // Frames with a wrong eid (or too short to carry one) are dropped
        // and the timeout keeps running from state entry.
        if (rsEnd && (rsCnt_q >= 3'd2) && match_q) begin
          ack_d   = (code_q == CODE_ACK);
          nak_d   = (code_q != CODE_ACK);
          state_d = ST_FINISH;
          if (type_q == CMD_VER) begin
            if (code_q == CODE_ACK) begin
              rdata_d = {VERSION_MAJOR, VERSION_MINOR};
            end else begin
              exp_d   = 2'd2;
              state_d = ST_WAIT_DATA;
            end
          end else if ((type_q == CMD_QUERY) && (code_q == CODE_ACK)) begin
            exp_d   = sel_q ? 2'd2 : 2'd1;
            state_d = ST_WAIT_DATA;
          end
        end else if (timeoutHit) begin
          to_d    = 1'b1;
          state_d = ST_FINISH;
        end
      end
      ST_WAIT_DATA: begin
        // Byte 0 is the length; payload is little-endian, extras dropped.
        if (rsByte) begin
          if (rsCnt_q == 3'd1)                          rdata_d[7:0]  = rs_data;
          else if ((rsCnt_q == 3'd2) && (exp_q == 2'd2)) rdata_d[15:8] = rs_data;
        end
        if (rsEnd) begin
          state_d = ST_FINISH;
        end else if (timeoutHit) begin
          to_d    = 1'b1;
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // The wait counter restarts whenever the state changes.
  assign cnt_d = (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      type_q   <= CMD_VER;
      sel_q    <= 1'b0;
      eid_q    <= 8'h00;
      ack_q    <= 1'b0;
      nak_q    <= 1'b0;
      to_q     <= 1'b0;
      rdata_q  <= 16'h0000;
      code_q   <= 8'h00;
      match_q  <= 1'b0;
      exp_q    <= 2'd0;
      cnt_q    <= 16'd0;
      rsPrev_q <= 1'b0;
      rsOpen_q <= 1'b0;
      rsCnt_q  <= 3'd0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      sel_q    <= sel_d;
      eid_q    <= eid_d;
      ack_q    <= ack_d;
      nak_q    <= nak_d;
      to_q     <= to_d;
      rdata_q  <= rdata_d;
      code_q   <= code_d;
      match_q  <= match_d;
      exp_q    <= exp_d;
      cnt_q    <= cnt_d;
      rsPrev_q <= rs_frame_valid;
      rsOpen_q <= rsOpenNow;
      if (!rsOpenNow)                     rsCnt_q <= 3'd0;
      else if (rsByte && rsCnt_q != 3'd7) rsCnt_q <= rsCnt_q + 3'd1;
    end
  end

  assign cmd_busy = (state_q != ST_IDLE);
  assign done     = (state_q == ST_FINISH);
  assign ack      = ack_q;
  assign nak      = nak_q;
  assign timeout  = to_q;
  assign rdata    = rdata_q;
  assign eid      = eid_q;

endmodule
